// File: rtl/handshake_arbiter.sv
// Round-robin arbiter that shares one handshake trigger channel among N local requesters,
// queuing one transfer per requester and reporting completion, timeout and dropped requests.
module handshake_arbiter #(
    parameter int N              = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] request,
    input  logic         hs_busy,
    output logic         hs_trigger,
    output logic [N-1:0] grant,
    output logic [N-1:0] pending,
    output logic [N-1:0] done,
    output logic [N-1:0] timeout,
    output logic [N-1:0] dropped,
    output logic         active
);
    localparam int IDX_W = $clog2(N);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(N - 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;

    state_t           state_reg;
    logic [TMR_W-1:0] timer_reg;
    logic [IDX_W-1:0] last_reg;
    logic [N-1:0]     grant_reg;
    logic [N-1:0]     pending_reg;
    logic [N-1:0]     done_reg;
    logic [N-1:0]     timeout_reg;
    logic [N-1:0]     dropped_reg;
    logic             hs_trigger_reg;
    logic             active_reg;

    logic [IDX_W-1:0] cand_idx [N];
    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [N-1:0]     win_onehot;
    logic             grant_now;
    logic [N-1:0]     clear_vec;
    logic [N-1:0]     pending_next;
    logic [N-1:0]     dropped_next;
    logic             timer_expired;

    // Search order starts just after the last owner and wraps around.
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        assign cand_idx[gi] = IDX_W'((int'(last_reg) + 1 + gi) % N);
    end

    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        for (int i = 0; i < N; i++) begin
            if (!win_found && pending_reg[cand_idx[i]]) begin
                win_found = 1'b1;
                win_idx   = cand_idx[i];
            end
        end
        win_onehot          = '0;
        win_onehot[win_idx] = win_found;
    end

    assign grant_now     = (state_reg == IDLE) && win_found && !hs_busy;
    assign clear_vec     = grant_now ? win_onehot : '0;
    // A request landing on the edge that grants the same requester re-queues it instead of dropping.
    assign pending_next  = (pending_reg & ~clear_vec) | request;
    assign dropped_next  = request & pending_reg & ~clear_vec;
    assign timer_expired = (timer_reg == TMR_LIMIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            timer_reg      <= '0;
            last_reg       <= LAST_INIT;
            grant_reg      <= '0;
            pending_reg    <= '0;
            done_reg       <= '0;
            timeout_reg    <= '0;
            dropped_reg    <= '0;
            hs_trigger_reg <= 1'b0;
            active_reg     <= 1'b0;
        end else begin
            pending_reg    <= pending_next;
            dropped_reg    <= dropped_next;
            done_reg       <= '0;
            timeout_reg    <= '0;
            hs_trigger_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_now) begin
                        grant_reg      <= win_onehot;
                        hs_trigger_reg <= 1'b1;
                        last_reg       <= win_idx;
                        timer_reg      <= '0;
                        state_reg      <= WAIT_HI;
                        active_reg     <= 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (hs_busy) begin
                        timer_reg <= '0;
                        state_reg <= WAIT_LO;
                    end else if (timer_expired) begin
                        timeout_reg <= grant_reg;
                        grant_reg   <= '0;
                        state_reg   <= IDLE;
                        active_reg  <= 1'b0;
                    end else begin
                        timer_reg <= timer_reg + TMR_W'(1);
                    end
                end
                WAIT_LO: begin
                    if (!hs_busy) begin
                        done_reg   <= grant_reg;
                        grant_reg  <= '0;
                        state_reg  <= IDLE;
                        active_reg <= 1'b0;
                    end else if (timer_expired) begin
                        timeout_reg <= grant_reg;
                        grant_reg   <= '0;
                        state_reg   <= IDLE;
                        active_reg  <= 1'b0;
                    end else begin
                        timer_reg <= timer_reg + TMR_W'(1);
                    end
                end
                default: begin
                    grant_reg  <= '0;
                    state_reg  <= IDLE;
                    active_reg <= 1'b0;
                end
            endcase
        end
    end

    assign hs_trigger = hs_trigger_reg;
    assign grant      = grant_reg;
    assign pending    = pending_reg;
    assign done       = done_reg;
    assign timeout    = timeout_reg;
    assign dropped    = dropped_reg;
    assign active     = active_reg;

endmodule

// File: tb/tb_handshake_arbiter.sv
// Directed bench for handshake_arbiter: a vector table plus sequences for handshake timing,
// fairness, timeout and reset mid-transfer.
module tb_handshake_arbiter;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] request = '0;
    logic       hs_busy = 1'b0;
    logic       hs_trigger;
    logic [3:0] grant, pending, done, timeout, dropped;
    logic       active;

    logic [3:0] request_b = '0;
    logic       busy_b = 1'b0;
    logic       hs_trigger_b;
    logic [3:0] grant_b, pending_b, done_b, timeout_b, dropped_b;
    logic       active_b;

    int n_pass  = 0;
    int n_total = 0;

    // Bench-side model of a handshake channel: busy rises one edge after the trigger is seen
    // and stays high for 10 cycles.
    bit auto_busy = 1'b0;
    int hs_delay  = 0;
    int hs_hold   = 0;
    bit hs_fell   = 1'b0;

    typedef struct {
        logic [3:0] req;
        logic       busy;
        logic [3:0] grant;
        logic       trig;
        logic [3:0] pend;
        logic [3:0] done;
        logic [3:0] drop;
        logic       act;
    } vec_t;
    vec_t vecs [24];
    int fair_exp [5] = '{0, 1, 2, 3, 0};
    int got [8];

    handshake_arbiter #(.N(4), .TIMEOUT_CYCLES(255)) dut (
        .clock(clock), .reset(reset), .request(request), .hs_busy(hs_busy),
        .hs_trigger(hs_trigger), .grant(grant), .pending(pending), .done(done),
        .timeout(timeout), .dropped(dropped), .active(active)
    );

    handshake_arbiter #(.N(4), .TIMEOUT_CYCLES(8)) dut_to (
        .clock(clock), .reset(reset), .request(request_b), .hs_busy(busy_b),
        .hs_trigger(hs_trigger_b), .grant(grant_b), .pending(pending_b), .done(done_b),
        .timeout(timeout_b), .dropped(dropped_b), .active(active_b)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        hs_fell = 1'b0;
        if (auto_busy) begin
            if (hs_hold > 0) begin
                hs_hold--;
                if (hs_hold == 0) begin
                    hs_busy = 1'b0;
                    hs_fell = 1'b1;
                end
            end
            if (hs_delay > 0) begin
                hs_delay--;
                if (hs_delay == 0) begin
                    hs_busy = 1'b1;
                    hs_hold = 10;
                end
            end
            if (hs_trigger) hs_delay = 1;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        request   = '0;
        request_b = '0;
        hs_busy   = 1'b0;
        busy_b    = 1'b0;
        hs_delay  = 0;
        hs_hold   = 0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] outputs_a();
        return 32'({timeout, grant, hs_trigger, pending, done, dropped, active});
    endfunction

    function automatic int oh_idx(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = (r == -1) ? i : 99;
        return r;
    endfunction

    initial begin
        int k;
        int extra;
        int ngrant;
        int early;
        bit injected;
        logic [3:0] done_seen;

        //            req     busy  grant   trig  pend    done    drop    act
        vecs[0]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0};
        vecs[1]  = '{4'b0010, 1'b0, 4'b0001, 1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b1};
        vecs[2]  = '{4'b0010, 1'b0, 4'b0001, 1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b1};
        vecs[3]  = '{4'b0000, 1'b1, 4'b0001, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b1};
        vecs[4]  = '{4'b0000, 1'b1, 4'b0001, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b1};
        vecs[5]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0010, 4'b0001, 4'b0000, 1'b0};
        vecs[6]  = '{4'b0000, 1'b0, 4'b0010, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1};
        vecs[7]  = '{4'b0100, 1'b0, 4'b0010, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1};
        vecs[8]  = '{4'b0000, 1'b1, 4'b0010, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1};
        vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0100, 4'b0010, 4'b0000, 1'b0};
        vecs[10] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b1};
        vecs[11] = '{4'b0000, 1'b1, 4'b0100, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1};
        vecs[12] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b0};
        vecs[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0};
        vecs[14] = '{4'b0000, 1'b0, 4'b0100, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1};
        vecs[15] = '{4'b0001, 1'b1, 4'b0100, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1};
        vecs[16] = '{4'b0100, 1'b0, 4'b0000, 1'b0, 4'b0101, 4'b0100, 4'b0000, 1'b0};
        vecs[17] = '{4'b0000, 1'b0, 4'b0001, 1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b1};
        vecs[18] = '{4'b0000, 1'b1, 4'b0001, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1};
        vecs[19] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0100, 4'b0001, 4'b0000, 1'b0};
        vecs[20] = '{4'b0000, 1'b0, 4'b0100, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1};
        vecs[21] = '{4'b0000, 1'b1, 4'b0100, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1};
        vecs[22] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0100, 4'b0000, 1'b0};
        vecs[23] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};

        // Reset state and table vectors with a hand-driven busy line.
        auto_busy = 1'b0;
        do_reset();
        check("reset_outputs", outputs_a(), 32'd0);
        for (int i = 0; i < 24; i++) begin
            request = vecs[i].req;
            hs_busy = vecs[i].busy;
            tick();
            check($sformatf("vec%0d", i), outputs_a(),
                  32'({4'b0000, vecs[i].grant, vecs[i].trig, vecs[i].pend,
                       vecs[i].done, vecs[i].drop, vecs[i].act}));
        end
        request = '0;
        hs_busy = 1'b0;

        // Single request against the modelled handshake channel.
        auto_busy = 1'b1;
        do_reset();
        request = 4'b0001;
        tick();
        check("single_pending", 32'(pending), 32'b0001);
        check("single_no_grant_yet", 32'(grant), 32'b0000);
        request = '0;
        tick();
        check("single_grant", 32'(grant), 32'b0001);
        check("single_trigger", 32'(hs_trigger), 32'd1);
        check("single_pend_clear", 32'(pending), 32'b0000);
        tick();
        check("single_trigger_width", 32'(hs_trigger), 32'd0);
        k = 1;
        extra = 0;
        while (done == 4'b0000 && k < 40) begin
            tick();
            k++;
            if (hs_trigger) extra++;
        end
        check("single_done_latency", k, 32'd12);
        check("single_done", 32'(done), 32'b0001);
        check("single_grant_release", 32'(grant), 32'b0000);
        check("single_active_low", 32'(active), 32'd0);
        check("single_no_retrigger", extra, 32'd0);
        tick();
        check("single_done_pulse_width", 32'(done), 32'b0000);

        // Fairness: 1111 at once, then 1111 again on the edge that completes requester 0.
        do_reset();
        request = 4'b1111;
        tick();
        request = '0;
        ngrant = 0;
        injected = 1'b0;
        for (int c = 0; c < 300 && !(ngrant == 5 && !active); c++) begin
            tick();
            if (hs_trigger) begin
                if (ngrant < 8) got[ngrant] = oh_idx(grant);
                ngrant++;
            end
            if (request != 4'b0000) begin
                check("fair_inject_done", 32'(done), 32'b0001);
                check("fair_inject_dropped", 32'(dropped), 32'b1110);
                check("fair_inject_pending", 32'(pending), 32'b1111);
                request = '0;
            end else if (!injected && hs_fell && grant == 4'b0001) begin
                request = 4'b1111;
                injected = 1'b1;
            end
        end
        check("fair_injected", 32'(injected), 32'd1);
        check("fair_grant_count", ngrant, 32'd5);
        for (int i = 0; i < 5; i++) check($sformatf("fair_order%0d", i), got[i], fair_exp[i]);
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (hs_trigger) extra++;
        end
        check("fair_no_extra_grant", extra, 32'd0);

        // Timeout on the TIMEOUT_CYCLES=8 instance with busy held low.
        auto_busy = 1'b0;
        do_reset();
        request_b = 4'b0011;
        tick();
        check("to_pending", 32'(pending_b), 32'b0011);
        request_b = '0;
        tick();
        check("to_grant0", 32'(grant_b), 32'b0001);
        done_seen = '0;
        early = 0;
        for (int c = 1; c < 8; c++) begin
            tick();
            done_seen |= done_b;
            if (timeout_b != 4'b0000 || grant_b != 4'b0001) early++;
        end
        check("to_not_early0", early, 32'd0);
        tick();
        check("to_timeout0", 32'(timeout_b), 32'b0001);
        check("to_grant0_release", 32'(grant_b), 32'b0000);
        tick();
        check("to_timeout_width", 32'(timeout_b), 32'b0000);
        check("to_next_grant", 32'(grant_b), 32'b0010);
        check("to_next_trigger", 32'(hs_trigger_b), 32'd1);
        for (int c = 1; c < 8; c++) begin
            tick();
            done_seen |= done_b;
        end
        tick();
        done_seen |= done_b;
        check("to_timeout1", 32'(timeout_b), 32'b0010);
        check("to_no_done", 32'(done_seen), 32'b0000);

        // Reset while WAIT_LO with the channel still busy.
        do_reset();
        request = 4'b0001;
        tick();
        request = '0;
        tick();
        check("rm_grant", 32'(grant), 32'b0001);
        hs_busy = 1'b1;
        request = 4'b0110;
        tick();
        check("rm_pending", 32'(pending), 32'b0110);
        check("rm_active", 32'(active), 32'd1);
        request = 4'b1000;
        reset = 1'b1;
        tick();
        check("rm_reset_outputs", outputs_a(), 32'd0);
        reset = 1'b0;
        request = '0;
        tick();
        tick();
        tick();
        check("rm_idle_after_reset", outputs_a(), 32'd0);
        request = 4'b0011;
        tick();
        check("rm_pending_while_busy", 32'(pending), 32'b0011);
        check("rm_hold_off0", 32'(grant), 32'b0000);
        request = '0;
        tick();
        check("rm_hold_off1", 32'(grant), 32'b0000);
        hs_busy = 1'b0;
        tick();
        check("rm_first_grant", 32'(grant), 32'b0001);
        check("rm_first_trigger", 32'(hs_trigger), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/handshake_arbiter.md
# handshake_arbiter

Round-robin arbiter and sequencer that shares one `handshake` cross-clock trigger channel among N requesters in the channel's source clock domain. It queues one pending trigger per requester. It issues a single-cycle trigger to the channel only when the channel is not busy, and tracks the in-flight owner until the channel's busy drops. It then reports per-requester completion, and reports a timeout if the channel stalls. It sits between local event sources (e.g. `edge_to_pulse` or `button_debounce` outputs) and the `input_trigger_a`/`busy` pins of a `handshake` instance.

## Interface
- `N`, default 4: number of requesters; must be ≥ 2.
- `TIMEOUT_CYCLES`, default 255: per-phase cycle limit while waiting on the channel; must be ≥ 4.
- `clock`  in  1  single clock, rising edge; same clock as the handshake `clock_a`.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clock`.
- `request`  in  N  per-requester trigger; each cycle sampled high queues one transfer.
- `hs_busy`  in  1  channel busy, wired from handshake `busy`.
- `hs_trigger`  out  1  single-cycle trigger, wired to handshake `input_trigger_a`.
- `grant`  out  N  one-hot owner of the in-flight transfer; all zero when none.
- `pending`  out  N  queued, not-yet-granted requests.
- `done`  out  N  one-cycle pulse when the owner's transfer completes.
- `timeout`  out  N  one-cycle pulse when the owner's transfer is abandoned.
- `dropped`  out  N  one-cycle pulse when a request hits an already-set pending bit.
- `active`  out  1  high whenever the state is not IDLE.

## Operation
- All outputs are registered. Reset value of every output is 0.
- Internal state after reset: state=IDLE, timer=0, `last`=N-1, so requester 0 has first priority.
- Pending bits:
  - `request[k]` sampled high with `pending[k]`=0: set `pending[k]`.
  - `request[k]` sampled high with `pending[k]`=1: `pending[k]` unchanged; `dropped[k]` pulses for one cycle.
  - Only one transfer per requester is ever queued.
- Round-robin selection: search `pending` starting at index (`last`+1) mod N, ascending with wrap. The first set bit wins.
- FSM states: IDLE, WAIT_HI, WAIT_LO.
- IDLE, when `pending`≠0 and `hs_busy`=0, for winner k:
  - `grant`=onehot(k), `hs_trigger`=1, `pending[k]` cleared, `last`=k, timer=0.
  - Go to WAIT_HI.
  - If `hs_busy`=1, stay in IDLE; no grant is issued.
- WAIT_HI:
  - `hs_trigger`=0.
  - If `hs_busy` is sampled 1: timer=0, go to WAIT_LO.
  - Otherwise timer+1.
- WAIT_LO:
  - If `hs_busy` is sampled 0: `done[k]`=1, `grant`=0, go to IDLE.
  - Otherwise timer+1.
- Timeout: in WAIT_HI or WAIT_LO, when timer reaches TIMEOUT_CYCLES-1 without the exit condition, `timeout[k]`=1, `grant`=0, go to IDLE.
  - The transfer is not retried.
  - IDLE still holds off until `hs_busy`=0.
- `done` and `timeout` never pulse in the same cycle. At most one bit of `grant`, `done` or `timeout` is set at a time.
- Timer width is $clog2(TIMEOUT_CYCLES+1). It must never wrap.
- `active` = (state≠IDLE).

## Timing
- Latency from request to trigger:
  - `request[k]` sampled at edge n gives `pending[k]`=1 after n.
  - With the channel idle and k the winner, `grant` and `hs_trigger` are high after edge n+1.
  - `pending[k]` is low after edge n+1.
- `hs_trigger` is high for exactly one cycle per grant.
- With a `handshake` instance driving `hs_busy`, busy is first sampled high at edge n+3.
- Completion: `done` and `grant`=0 appear after the first edge at which WAIT_LO samples `hs_busy`=0.
- The next grant comes one edge later at the earliest (one IDLE cycle).
- Same-cycle events:
  - `request[k]` sampled at the same edge that grants k: `pending[k]` ends at 1, queuing a new transfer, and `dropped[k]` stays 0.
  - `request[k]` sampled at the same edge that pulses `done[k]`: queued normally.
- Reset at any edge, including mid-transfer: all outputs 0 and state IDLE after that edge; pending requests are discarded. A channel still busy from before the reset delays the first grant until `hs_busy`=0.
- `request` sampled during reset is ignored.

## Test plan
- Single request, with `hs_busy` modelled as a handshake (high 2 cycles after the trigger, low 10 cycles later):
  - `request`=0001 for 1 cycle.
  - Required: `grant`=0001 and `hs_trigger`=1 one edge later, with `hs_trigger` for 1 cycle.
  - `done`=0001 the cycle after busy is sampled low, then `grant`=0000.
- Fairness:
  - `request`=1111 for 1 cycle.
  - Required: grants in order 0,1,2,3.
  - Then re-request 1111 right after `done[0]`: the next grants follow as 1,2,3,0 from `last`.
- Duplicate:
  - `request`=0010 on 2 consecutive cycles while requester 0 is in flight.
  - Required: `dropped`=0010 on the second cycle; requester 1 is granted exactly once.
- Same-edge re-request:
  - `request[2]` asserted on the grant edge for 2.
  - Required: `pending[2]`=1 afterwards, a second transfer for 2 follows, and `dropped`=0.
- Timeout:
  - TIMEOUT_CYCLES=8, `hs_busy` held 0.
  - Required: `timeout`=0001 exactly 8 cycles after the grant, `grant`=0; the next pending requester is granted on the following edge.
- Reset mid-transfer:
  - Assert `reset` in WAIT_LO with `hs_busy`=1 and `pending`=0110.
  - Required: all outputs 0. After release, no grant until `hs_busy`=0. The first grant after reset goes to requester 0.
